// File: rtl/detector_scheduler.sv
// detector_scheduler: round-robin time-sharing of one serial run-of-ones detector across NREQ sources.
// Build option DET_OVERLAP_EN: after a hit the run counter holds at RUN_LEN-1 (overlapping detection).
module detector_scheduler #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8,
  parameter int RUN_LEN   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         bit_in,
  output logic [NREQ-1:0]         grant,
  output logic                    sample_en,
  output logic                    busy,
  output logic                    det_valid,
  output logic [$clog2(NREQ)-1:0] det_id,
  input  logic [$clog2(NREQ)-1:0] rd_id,
  output logic [CNT_W-1:0]        rd_count
);

  // state    | meaning
  // ST_IDLE  | no owner; arbitrate among requesters
  // ST_CLEAR | owner granted; run/frame counters cleared, bit_in ignored
  // ST_RUN   | owner's stream sampled once per cycle while it holds req
  // ST_DONE  | frame closed; owner becomes last_grant
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = $clog2(RUN_LEN + 1);
  localparam int FW  = $clog2(FRAME_LEN + 1);

`ifdef DET_OVERLAP_EN
  localparam logic [RW-1:0] RUN_AFTER_HIT = RW'(RUN_LEN - 1);
`else
  localparam logic [RW-1:0] RUN_AFTER_HIT = '0;
`endif

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic             det_valid_q, det_valid_d;
  logic [IDW-1:0]   det_id_q, det_id_d;
  logic [CNT_W-1:0] hit_cnt_q [NREQ];
  logic [CNT_W-1:0] hit_cnt_d [NREQ];

  logic             arb_found;
  logic [IDW-1:0]   arb_idx;
  logic [IDW-1:0]   cand;
  logic [RW-1:0]    run_inc;

  // Round-robin: first requester strictly after last_grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    run_cnt_d    = run_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    det_valid_d  = 1'b0;
    det_id_d     = '0;
    hit_cnt_d    = hit_cnt_q;
    run_inc      = run_cnt_q + RW'(1);
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          owner_d = arb_idx;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        run_cnt_d   = '0;
        frame_cnt_d = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // Owner dropping req aborts the frame; that cycle's bit is not sampled.
        if (!req[owner_q]) begin
          state_d = ST_DONE;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
          if (frame_cnt_q == FW'(FRAME_LEN - 1)) begin
            state_d = ST_DONE;
          end
          if (!bit_in[owner_q]) begin
            run_cnt_d = '0;
          end else if (run_inc == RW'(RUN_LEN)) begin
            det_valid_d = 1'b1;
            det_id_d    = owner_q;
            run_cnt_d   = RUN_AFTER_HIT;
            if (hit_cnt_q[owner_q] != '1) begin
              hit_cnt_d[owner_q] = hit_cnt_q[owner_q] + CNT_W'(1);
            end
          end else begin
            run_cnt_d = run_inc;
          end
        end
      end
      ST_DONE: begin
        last_grant_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      run_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      det_valid_q  <= 1'b0;
      det_id_q     <= '0;
      hit_cnt_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      run_cnt_q    <= run_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      det_valid_q  <= det_valid_d;
      det_id_q     <= det_id_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == ST_CLEAR || state_q == ST_RUN) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign sample_en = (state_q == ST_RUN) && req[owner_q];
  assign busy      = (state_q != ST_IDLE);
  assign det_valid = det_valid_q;
  assign det_id    = det_id_q;

  // Out-of-range selects match no requester and read 0.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_id == IDW'(i)) begin
        rd_count = hit_cnt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_detector_scheduler.sv
// tb_detector_scheduler: directed checks of arbitration, frame timing, detection and hit counters.
module tb_detector_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] grant;
  logic       sample_en;
  logic       busy;
  logic       det_valid;
  logic [1:0] det_id;
  logic [1:0] rd_id;
  logic [7:0] rd_count;

  logic [15:0] stream [4];
  logic [3:0]  ptr [4];
  logic        ptr_clr;
  int          pulses = 0;
  int          p0;
  int          vecs = 0;
  int          errs = 0;

`ifdef DET_OVERLAP_EN
  localparam int EXP4 = 5;
`else
  localparam int EXP4 = 2;
`endif

  detector_scheduler #(.NREQ(4), .FRAME_LEN(8), .RUN_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .grant(grant),
    .sample_en(sample_en), .busy(busy), .det_valid(det_valid), .det_id(det_id),
    .rd_id(rd_id), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each source advances its stream only when it is sampled.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ptr_clr) ptr[i] <= '0;
      else if (sample_en && grant[i]) ptr[i] <= ptr[i] + 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) bit_in[i] = stream[i][ptr[i]];
  end

  always @(negedge clk) if (det_valid) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; req = 4'b1111; rd_id = 2'd0; ptr_clr = 1'b1;
    for (int i = 0; i < 4; i++) stream[i] = 16'h0000;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_det_valid", 32'(det_valid), 32'h0);
    chk("rst_sample_en", 32'(sample_en), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_id = 2'(i); #1;
      chk("rst_rd_count", 32'(rd_count), 32'h0);
    end

    // Single frame for requester 0, stream 1111_0000
    stream[0] = 16'h000F;
    ptr_clr = 1'b0; reset = 1'b0; req = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("f0_grant", 32'(grant), 32'h1);
      chk("f0_sample_en", 32'(sample_en), (k >= 2) ? 32'h1 : 32'h0);
      chk("f0_det_valid", 32'(det_valid), (k == 6) ? 32'h1 : 32'h0);
    end
    tick();
    chk("f0_done_busy", 32'(busy), 32'h1);
    chk("f0_done_grant", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    chk("f0_idle_busy", 32'(busy), 32'h0);
    rd_id = 2'd0; #1;
    chk("f0_rd_count", 32'(rd_count), 32'h1);

    // Round-robin with everyone requesting, zero streams
    reset = 1'b1; ptr_clr = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) stream[i] = 16'h0000;
    tick();
    reset = 1'b0; ptr_clr = 1'b0;
    p0 = pulses;
    for (int f = 0; f < 5; f++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (f % 4)));
      if (f < 4) begin
        repeat (9) tick();
        chk("rr_done_grant", 32'(grant), 32'h0);
        chk("rr_done_busy", 32'(busy), 32'h1);
        tick();
        chk("rr_idle_busy", 32'(busy), 32'h0);
      end
    end
    chk("rr_no_pulses", 32'(pulses - p0), 32'h0);
    reset = 1'b1; req = 4'b0000;
    tick();

    // Requester 2, eight 1s
    stream[2] = 16'h00FF; ptr_clr = 1'b1;
    tick();
    reset = 1'b0; ptr_clr = 1'b0; req = 4'b0100;
    p0 = pulses;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("r2_grant", 32'(grant), 32'h4);
      if (k == 6) chk("r2_det6", 32'(det_valid), 32'h1);
    end
    chk("r2_done_det_valid", 32'(det_valid), 32'h1);
    chk("r2_done_det_id", 32'(det_id), 32'h2);
    chk("r2_done_grant", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    chk("r2_pulses", 32'(pulses - p0), 32'(EXP4));
    rd_id = 2'd2; #1;
    chk("r2_rd_count", 32'(rd_count), 32'(EXP4));

    // Requester 2, runs of three only
    stream[2] = 16'h0077; ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0; req = 4'b0100;
    p0 = pulses;
    repeat (10) tick();
    req = 4'b0000;
    tick();
    chk("r3_pulses", 32'(pulses - p0), 32'h0);
    chk("r3_busy", 32'(busy), 32'h0);
    chk("r3_rd_count", 32'(rd_count), 32'(EXP4));

    // Requester 0 aborts after its 3rd sample; requester 1 next
    stream[0] = 16'hFFFF; stream[1] = 16'h0000; stream[3] = 16'hFFFF; ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0; req = 4'b0011;
    p0 = pulses;
    tick();
    chk("ab_grant", 32'(grant), 32'h1);
    repeat (3) tick();
    tick();
    chk("ab_pre_sample_en", 32'(sample_en), 32'h1);
    req = 4'b0010; #1;
    chk("ab_sample_en", 32'(sample_en), 32'h0);
    chk("ab_grant_held", 32'(grant), 32'h1);
    tick();
    chk("ab_done_busy", 32'(busy), 32'h1);
    chk("ab_done_grant", 32'(grant), 32'h0);
    chk("ab_done_det_valid", 32'(det_valid), 32'h0);
    tick();
    chk("ab_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("ab_next_grant", 32'(grant), 32'h2);
    req = 4'b1000;
    tick();
    chk("ab2_sample_en", 32'(sample_en), 32'h0);
    tick(); tick();
    chk("ab_pulses", 32'(pulses - p0), 32'h0);
    rd_id = 2'd0; #1;
    chk("ab_rd_count0", 32'(rd_count), 32'h0);

    // Requester 3 owns; reset after three 1s sampled
    tick();
    chk("rs_grant", 32'(grant), 32'h8);
    repeat (3) tick();
    tick();
    chk("rs_sample_en", 32'(sample_en), 32'h1);
    chk("rs_grant_run", 32'(grant), 32'h8);
    rd_id = 2'd2; #1;
    chk("rs_pre_rd_count2", 32'(rd_count), 32'(EXP4));
    reset = 1'b1;
    tick();
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_grant_clr", 32'(grant), 32'h0);
    chk("rs_det_valid", 32'(det_valid), 32'h0);
    tick();
    chk("rs_pulses", 32'(pulses - p0), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_id = 2'(i); #1;
      chk("rs_rd_count", 32'(rd_count), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
